// File: rtl/quad_enc_pkg.sv
// Shared decode codes and saturating-add helper for the quadrature speed meter.
package quad_enc_pkg;

  localparam logic [1:0] QE_NONE = 2'd0;
  localparam logic [1:0] QE_FWD  = 2'd1;
  localparam logic [1:0] QE_REV  = 2'd2;
  localparam logic [1:0] QE_ILL  = 2'd3;

  // Adds d to acc, clamped to the signed range of a w-bit word.
  function automatic int sat_add(input int acc, input int d, input int w,
                                 output logic clamped);
    int sum;
    int hi;
    int lo;
    sum     = acc + d;
    hi      = (1 << (w - 1)) - 1;
    lo      = -(1 << (w - 1));
    clamped = 1'b0;
    if (sum > hi) begin
      sum     = hi;
      clamped = 1'b1;
    end else if (sum < lo) begin
      sum     = lo;
      clamped = 1'b1;
    end
    return sum;
  endfunction

endpackage

// File: rtl/quad_encoder_speed_if.sv
// Encoder pins in, latched per-window counts and strobe out.
interface quad_encoder_speed_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic                    enable;
  logic [N_CH-1:0]         enc_a;
  logic [N_CH-1:0]         enc_b;
  logic [N_CH*CNT_W-1:0]   speed;
  logic                    sample_valid;
  logic [N_CH-1:0]         sat;
  logic [N_CH-1:0]         err;

  modport master (output enable, enc_a, enc_b, input speed, sample_valid, sat, err);
  modport slave  (input enable, enc_a, enc_b, output speed, sample_valid, sat, err);
endinterface

// File: rtl/quad_decoder_ch.sv
// One encoder channel: synchronizer, A/B decode, saturating window accumulator.
module quad_decoder_ch
  import quad_enc_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DECODE_X4 = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    dec_en,
  input  logic                    tc,
  input  logic                    enc_a,
  input  logic                    enc_b,
  output logic signed [CNT_W-1:0] cnt,
  output logic                    sat,
  output logic                    err
);
  logic [1:0]              sync_a, sync_b;
  logic [1:0]              prev, cur;
  logic [1:0]              code;
  logic signed [CNT_W-1:0] acc;
  logic                    sat_q, err_q;
  logic                    clamp;
  int                      delta;
  int                      sum;

  assign cur = {sync_a[1], sync_b[1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      prev   <= '0;
    end else begin
      sync_a <= {sync_a[0], enc_a};
      sync_b <= {sync_b[0], enc_b};
      prev   <= cur;
    end
  end

  always_comb begin
    code = QE_NONE;
    if (dec_en && prev != cur) begin
      if (prev[1] != cur[1] && prev[0] != cur[0]) begin
        code = QE_ILL;
      end else if (DECODE_X4 != 0) begin
        case ({prev, cur})
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: code = QE_FWD;
          default:                                code = QE_REV;
        endcase
      end else if (!prev[1] && cur[1]) begin
        code = cur[0] ? QE_REV : QE_FWD;
      end
    end
  end

  // cnt/sat/err include this cycle's event so the TC cycle closes the window.
  always_comb begin
    clamp = 1'b0;
    delta = (code == QE_FWD) ? 1 : (code == QE_REV) ? -1 : 0;
    sum   = sat_add(int'(acc), delta, CNT_W, clamp);
    cnt   = CNT_W'(sum);
    sat   = sat_q | clamp;
    err   = err_q | (code == QE_ILL);
  end

  always_ff @(posedge clk) begin
    if (reset || !enable || tc) begin
      acc   <= '0;
      sat_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      acc   <= cnt;
      sat_q <= sat;
      err_q <= err;
    end
  end

endmodule

// File: rtl/quad_encoder_speed.sv
// Multi-channel quadrature speed meter: shared sample window, latched counts, valid strobe.
module quad_encoder_speed
  import quad_enc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int WINDOW_CYC = 50000,
  parameter int DECODE_X4  = 1
) (
  input logic                 clk,
  input logic                 reset,
  quad_encoder_speed_if.slave bus
);
  localparam int WIN_W = $clog2(WINDOW_CYC);

  logic [WIN_W-1:0]             win_cnt;
  logic [1:0]                   supp_cnt;
  logic                         tc, dec_en;
  logic [N_CH-1:0][CNT_W-1:0]   cnt;
  logic [N_CH-1:0]              ch_sat, ch_err;

  assign tc     = bus.enable && (win_cnt == WIN_W'(WINDOW_CYC - 1));
  // Sync regs preload from 0 after reset; hold decode off until prev/cur agree.
  assign dec_en = (supp_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt  <= '0;
      supp_cnt <= '0;
    end else begin
      if (!dec_en) supp_cnt <= supp_cnt + 2'd1;
      if (!bus.enable || tc) win_cnt <= '0;
      else                   win_cnt <= win_cnt + WIN_W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    quad_decoder_ch #(.CNT_W(CNT_W), .DECODE_X4(DECODE_X4)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .enable (bus.enable),
      .dec_en (dec_en),
      .tc     (tc),
      .enc_a  (bus.enc_a[g]),
      .enc_b  (bus.enc_b[g]),
      .cnt    (cnt[g]),
      .sat    (ch_sat[g]),
      .err    (ch_err[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.speed        <= '0;
      bus.sat          <= '0;
      bus.err          <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= tc;
      if (tc) begin
        bus.speed <= cnt;
        bus.sat   <= ch_sat;
        bus.err   <= ch_err;
      end
    end
  end

endmodule
